rt_mem_loader: RTL and testbench
================================

Name: rt_mem_loader

Overview:
- Hardware preloader for the racetrack data memory.
- Accepts a little-endian firmware byte stream and packs it into 32-bit words.
- Writes each word through the dp_ram port B request/valid handshake, then releases the core via fetch_enable.
- Sits between the firmware byte source (upstream) and the riscv_wrapper RAM port B / core fetch_enable (downstream).

Parameters:
- RAM_ADDR_WIDTH, 22, width of the port-B byte address.
- NUM_WORDS, 4088, words to load (16352 bytes / 4).
- BASE_ADDR, 0, first byte address written; must be word aligned.
- SETTLE_CYCLES, 3, idle cycles after the last rvalid before done.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for rvalid on one word.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin a load; sampled only in IDLE.
- byte_valid_i  in  1  upstream byte valid.
- byte_i  in  8  firmware byte, address order.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- owner_o  out  1  loader owns port B. The downstream mux forces LiM funct, we_funct and addr_range to 0 while this is high.
- en_b_o  out  1  port-B request strobe.
- we_b_o  out  1  write enable; 1 whenever owner_o = 1.
- be_b_o  out  4  byte enables; 4'hF whenever owner_o = 1.
- addr_b_o  out  RAM_ADDR_WIDTH  byte address, advances by 4 per word.
- wdata_b_o  out  32  packed word.
- rvalid_b_i  in  1  port-B write complete.
- words_loaded_o  out  16  count of completed words.
- busy_o  out  1  high from start acceptance until DONE or ERROR.
- done_o  out  1  load complete; sticky.
- error_o  out  1  rvalid timeout; sticky.
- fetch_enable_o  out  1  core fetch enable; equals done_o.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high (clk_i, rst_i).
  - On reset, state goes to IDLE and every output is 0 except addr_b_o = BASE_ADDR.
  - Byte counter, word counter, timeout counter and word register are cleared.
- IDLE:
  - start_i = 1 -> COLLECT, with addr = BASE_ADDR and words = 0.
  - start_i in any other state is ignored.
- COLLECT:
  - byte_ready_o = 1 in this state only.
  - Each byte_valid_i & byte_ready_o handshake stores byte_i into lane byte_cnt (lane 0 = bits 7:0); byte_cnt increments.
  - On the 4th byte, the full word {b3,b2,b1,b0} is registered into wdata_b_o and the state moves to ISSUE. Latency: last-byte handshake to en_b_o = 1 cycle.
- ISSUE:
  - en_b_o = 1 for exactly one cycle, then WAIT_VALID.
  - addr_b_o and wdata_b_o are stable from ISSUE until GAP ends.
- WAIT_VALID:
  - en_b_o = 0; rvalid_b_i is sampled each cycle.
  - rvalid_b_i = 1 -> GAP.
  - The timeout counter runs from 1. When it reaches TIMEOUT_CYCLES without rvalid -> ERROR.
  - rvalid arriving in the same cycle as the timeout wins and goes to GAP.
  - rvalid seen in ISSUE or GAP is ignored.
- GAP:
  - Lasts 1 cycle. addr += 4, modulo 2^RAM_ADDR_WIDTH. words_loaded_o += 1.
  - If the new count equals NUM_WORDS -> SETTLE; otherwise -> COLLECT.
- SETTLE:
  - owner_o stays 1 with en_b_o = 0 for SETTLE_CYCLES cycles, then DONE.
  - SETTLE_CYCLES = 0 goes straight to DONE.
- DONE:
  - owner_o = 0, busy_o = 0, done_o = fetch_enable_o = 1; held until reset.
- ERROR:
  - owner_o = 0, busy_o = 0, error_o = 1, fetch_enable_o = 0; held until reset.
- owner_o = busy_o in every state except IDLE (both 0 there).
- Upstream stalls:
  - byte_valid_i low mid-word simply holds COLLECT.
  - No timeout applies to upstream.
- Reset mid-operation:
  - A partial word is discarded and fetch_enable_o drops.
  - No en_b_o is emitted in the reset cycle.
- Elaboration checks:
  - BASE_ADDR[1:0] = 0.
  - BASE_ADDR + 4*NUM_WORDS <= 2^RAM_ADDR_WIDTH.
  - NUM_WORDS < 2^16.
  - TIMEOUT_CYCLES >= 1.

Decomposition:
- Shared package rt_mem_pkg:
  - loader_state_e enum: IDLE, COLLECT, ISSUE, WAIT_VALID, GAP, SETTLE, DONE, ERROR.
  - Constants WORD_BYTES = 4 and BE_ALL = 4'hF.
- One natural sub-module, rt_byte_packer: byte handshake plus 4-lane word register with a word_valid pulse and a clear input.
- The FSM, address/word counters and timeout stay in rt_mem_loader.

Test Plan:
- Basic load: NUM_WORDS = 4; stream bytes 00..0F with rvalid 2 cycles after each en.
  - Required: writes 0x03020100 @0x0, 0x07060504 @0x4, 0x0B0A0908 @0x8, 0x0F0E0D0C @0xC.
  - Exactly one en_b_o pulse per word; done_o and fetch_enable_o rise 3 cycles after the last GAP; words_loaded_o = 4.
- Upstream stalls: byte_valid_i toggles randomly.
  - Required: same words and addresses as the basic load; byte_ready_o never high outside COLLECT.
- Timeout: TIMEOUT_CYCLES = 8 and rvalid never asserted.
  - Required: error_o = 1 exactly 8 cycles after the en_b_o cycle; fetch_enable_o stays 0; owner_o drops.
- Race: rvalid_b_i arrives exactly at the timeout cycle.
  - Required: no error; the load proceeds to the next word.
- Reset mid-load: rst_i asserted after 2 bytes of word 1.
  - Required: all outputs 0 next cycle, addr_b_o = BASE_ADDR.
  - A restart with BASE_ADDR = 0x100 writes its first word at 0x100.
- Start ignored: start_i pulsed during WAIT_VALID and during DONE.
  - Required: no state change and no extra en_b_o.

Source files
------------

// File: rtl/rt_mem_pkg.sv
// rt_mem_pkg: shared state encoding and constants for the racetrack memory preloader
package rt_mem_pkg;
    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_VALID,
        GAP,
        SETTLE,
        DONE,
        ERROR
    } loader_state_e;
    localparam int WORD_BYTES = 4;
    localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/rt_byte_packer.sv
// rt_byte_packer: byte handshake and little-endian 4-lane word assembly
module rt_byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] lanes_q, lanes_d;
    logic        fire;

    assign byte_ready_o = en_i;
    assign fire         = en_i & byte_valid_i;
    assign word_valid_o = fire && cnt_q == 2'd3;
    // The 4th byte goes straight into the word so it can be registered by the caller this cycle
    assign word_o       = {byte_i, lanes_q};

    always_comb begin
        cnt_d   = clr_i ? 2'd0 : fire ? cnt_q + 2'd1 : cnt_q;
        lanes_d = clr_i ? '0 : lanes_q;
        if (!clr_i && fire && cnt_q != 2'd3) lanes_d[{cnt_q, 3'b000} +: 8] = byte_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            lanes_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lanes_q <= lanes_d;
        end
    end
endmodule

// File: rtl/rt_mem_loader.sv
// rt_mem_loader: packs a firmware byte stream into words, writes them over RAM port B, then releases fetch
module rt_mem_loader
    import rt_mem_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 22,
    parameter int NUM_WORDS      = 4088,
    parameter int BASE_ADDR      = 0,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      byte_valid_i,
    input  logic [7:0]                byte_i,
    output logic                      byte_ready_o,
    output logic                      owner_o,
    output logic                      en_b_o,
    output logic                      we_b_o,
    output logic [3:0]                be_b_o,
    output logic [RAM_ADDR_WIDTH-1:0] addr_b_o,
    output logic [31:0]               wdata_b_o,
    input  logic                      rvalid_b_i,
    output logic [15:0]               words_loaded_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      fetch_enable_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1) + 1;
    localparam logic [RAM_ADDR_WIDTH-1:0] BASE = RAM_ADDR_WIDTH'(BASE_ADDR);

    if (BASE_ADDR % WORD_BYTES != 0) begin : g_bad_align
        $error("BASE_ADDR must be word aligned");
    end
    if (longint'(BASE_ADDR) + longint'(WORD_BYTES) * longint'(NUM_WORDS) > (longint'(1) << RAM_ADDR_WIDTH)) begin : g_bad_range
        $error("image does not fit in the port-B address space");
    end
    if (NUM_WORDS >= 65536) begin : g_bad_words
        $error("NUM_WORDS must fit the 16-bit word counter");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    loader_state_e             state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]               words_q, words_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               wdata_q, wdata_d, word;
    logic                      word_valid;

    rt_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (state_q == IDLE),
        .en_i         (state_q == COLLECT),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            words_q <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
        end
    end

    // cnt_q counts WAIT_VALID cycles from 1 and is reused to time SETTLE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = COLLECT;
                addr_d  = BASE;
                words_d = '0;
            end
            COLLECT: if (word_valid) begin
                state_d = ISSUE;
                wdata_d = word;
            end
            ISSUE: begin
                state_d = WAIT_VALID;
                cnt_d   = CNT_W'(1);
            end
            WAIT_VALID: begin
                if (rvalid_b_i) state_d = GAP;
                else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
                else cnt_d = cnt_q + 1'b1;
            end
            GAP: begin
                addr_d  = addr_q + RAM_ADDR_WIDTH'(WORD_BYTES);
                words_d = words_q + 16'd1;
                cnt_d   = CNT_W'(1);
                state_d = words_d == 16'(NUM_WORDS) ? (SETTLE_CYCLES == 0 ? DONE : SETTLE) : COLLECT;
            end
            SETTLE: begin
                if (cnt_q >= CNT_W'(SETTLE_CYCLES)) state_d = DONE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        owner_o        = !(state_q inside {IDLE, DONE, ERROR});
        busy_o         = owner_o;
        we_b_o         = owner_o;
        be_b_o         = owner_o ? BE_ALL : 4'h0;
        en_b_o         = state_q == ISSUE;
        done_o         = state_q == DONE;
        error_o        = state_q == ERROR;
        fetch_enable_o = state_q == DONE;
    end

    assign addr_b_o       = addr_q;
    assign wdata_b_o      = wdata_q;
    assign words_loaded_o = words_q;
endmodule

// File: tb/tb_rt_mem_loader.sv
// tb_rt_mem_loader: randomized scoreboard bench for the port-B firmware preloader
module tb_rt_mem_loader;
    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, bv = 1'b0, rvalid = 1'b0, sel = 1'b0;
    logic [7:0] bi = 8'h00;
    always #5 clk = ~clk;

    logic a_ready, a_owner, a_en, a_we, a_busy, a_done, a_err, a_fetch;
    logic b_ready, b_owner, b_en, b_we, b_busy, b_done, b_err, b_fetch;
    logic [3:0]  a_be, b_be;
    logic [21:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [15:0] a_words, b_words;

    rt_mem_loader #(.RAM_ADDR_WIDTH(22), .NUM_WORDS(4), .BASE_ADDR(0), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(8)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .byte_valid_i(bv), .byte_i(bi), .byte_ready_o(a_ready),
        .owner_o(a_owner), .en_b_o(a_en), .we_b_o(a_we), .be_b_o(a_be), .addr_b_o(a_addr), .wdata_b_o(a_wdata),
        .rvalid_b_i(rvalid), .words_loaded_o(a_words), .busy_o(a_busy), .done_o(a_done), .error_o(a_err),
        .fetch_enable_o(a_fetch));

    rt_mem_loader #(.RAM_ADDR_WIDTH(22), .NUM_WORDS(4), .BASE_ADDR('h100), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(8)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .byte_valid_i(bv), .byte_i(bi), .byte_ready_o(b_ready),
        .owner_o(b_owner), .en_b_o(b_en), .we_b_o(b_we), .be_b_o(b_be), .addr_b_o(b_addr), .wdata_b_o(b_wdata),
        .rvalid_b_i(rvalid), .words_loaded_o(b_words), .busy_o(b_busy), .done_o(b_done), .error_o(b_err),
        .fetch_enable_o(b_fetch));

    logic        m_ready, m_owner, m_en, m_we, m_busy, m_done, m_err, m_fetch;
    logic [3:0]  m_be;
    logic [21:0] m_addr;
    logic [31:0] m_wdata;
    logic [15:0] m_words;
    assign m_ready = sel ? b_ready : a_ready;
    assign m_owner = sel ? b_owner : a_owner;
    assign m_en    = sel ? b_en    : a_en;
    assign m_we    = sel ? b_we    : a_we;
    assign m_be    = sel ? b_be    : a_be;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_err   = sel ? b_err   : a_err;
    assign m_fetch = sel ? b_fetch : a_fetch;
    assign m_addr  = sel ? b_addr  : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;
    assign m_words = sel ? b_words : a_words;

    int total = 0, bad = 0, cyc = 0, en_cnt = 0, en_cyc = 0, en_base = 0, rv_delay = 2;
    bit inflight = 1'b0;
    logic prev_en = 1'b0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every port-B request is popped against the expected write queue
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            inflight = 1'b0;
            prev_en  = 1'b0;
        end else begin
            if (m_en) begin
                en_cnt++;
                en_cyc   = cyc;
                inflight = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_en: got write %0h @%0h, required no write", m_wdata, m_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(m_addr), {32'd0, e[63:32]});
                    chk("wr_data", 64'(m_wdata), {32'd0, e[31:0]});
                end
                chk("en_single_cycle", 64'(prev_en), 64'd0);
            end
            if (rvalid) inflight = 1'b0;
            if (m_ready) chk("ready_outside_collect", 64'(inflight | m_done | m_err | !m_busy | m_en), 64'd0);
            chk("we_be_follow_owner", 64'({m_we, m_be}), 64'({5{m_owner}}));
            chk("owner_eq_busy", 64'(m_owner), 64'(m_busy));
            chk("fetch_eq_done", 64'(m_fetch), 64'(m_done));
            prev_en = m_en;
        end
    end

    // Port-B responder: rvalid_b_i pulses rv_delay cycles after each request (0 = never)
    initial begin
        forever begin
            @(negedge clk);
            if (m_en && rv_delay > 0) begin
                @(posedge clk); #1;
                repeat (rv_delay - 1) begin @(posedge clk); #1; end
                rvalid = 1'b1;
                @(posedge clk); #1;
                rvalid = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n = 0;
        if (stall) while ($urandom_range(0, 1) == 1) begin bv = 1'b0; @(posedge clk); #1; end
        bv = 1'b1;
        bi = b;
        @(negedge clk);
        while (!m_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("byte_accept_timeout", 64'(m_ready), 64'd1);
        @(posedge clk); #1;
        bv = 1'b0;
    endtask

    task automatic send_word(input int base, input int k, input bit seq, input bit stall);
        logic [31:0] w;
        logic [7:0]  b;
        for (int j = 0; j < 4; j++) begin
            b = seq ? 8'(k * 4 + j) : 8'($urandom);
            w[j*8 +: 8] = b;
            send_byte(b, stall);
        end
        exp_q.push_back({32'(base + 4 * k), w});
    endtask

    task automatic pulse_start(input bit which);
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_load(input bit which, input int base, input bit seq, input bit stall, input bit start_in_wait);
        en_base = en_cnt;
        pulse_start(which);
        for (int k = 0; k < 4; k++) begin
            send_word(base, k, seq, stall);
            if (start_in_wait && k == 0) begin @(posedge clk); #1; pulse_start(which); end
        end
    endtask

    task automatic wait_done(input int nw);
        int n = 0;
        @(negedge clk);
        while (m_words !== 16'(nw) && n < 300) begin @(negedge clk); n++; end
        chk("words_loaded", 64'(m_words), 64'(nw));
        n = 0;
        while (!m_done && n < 50) begin @(negedge clk); n++; end
        chk("settle_cycles", 64'(n), 64'd3);
        chk("done_state", 64'({m_done, m_fetch, m_owner, m_busy, m_err}), 64'b11000);
        chk("en_pulses", 64'(en_cnt - en_base), 64'(nw));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 64'({a_ready, a_owner, a_en, a_we, a_be, a_busy, a_done, a_err, a_fetch}), 64'd0);
        chk("rst_addr_a", 64'(a_addr), 64'h0);
        chk("rst_addr_b", 64'(b_addr), 64'h100);
        chk("rst_words", 64'(a_words), 64'd0);
        chk("rst_wdata", 64'(a_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        rv_delay = 2;
        run_load(1'b0, 0, 1'b1, 1'b0, 1'b0);
        wait_done(4);
        do_reset();
        chk("fetch_drops_on_reset", 64'({a_fetch, a_done}), 64'd0);

        run_load(1'b0, 0, 1'b1, 1'b1, 1'b0);
        wait_done(4);

        // rvalid on the last allowed wait cycle must win over the timeout
        do_reset();
        rv_delay = 7;
        run_load(1'b0, 0, 1'b0, 1'b0, 1'b1);
        wait_done(4);
        n = en_cnt;
        pulse_start(1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("done_held", 64'({a_done, a_fetch, a_busy}), 64'b110);
        chk("words_held", 64'(a_words), 64'd4);
        chk("no_extra_en", 64'(en_cnt - n), 64'd0);

        do_reset();
        rv_delay = 0;
        pulse_start(1'b0);
        send_word(0, 0, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!a_err && n < 100) begin @(negedge clk); n++; end
        chk("timeout_latency", 64'(cyc - en_cyc), 64'd8);
        chk("error_state", 64'({a_err, a_fetch, a_owner, a_busy, a_done}), 64'b10000);
        chk("timeout_queue", 64'(exp_q.size()), 64'd0);

        do_reset();
        rv_delay = 2;
        pulse_start(1'b0);
        send_word(0, 0, 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("no_en_in_reset", 64'(a_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midload_rst_ctl", 64'({a_ready, a_owner, a_en, a_we, a_be, a_busy, a_done, a_err, a_fetch}), 64'd0);
        chk("midload_rst_addr", 64'(a_addr), 64'h0);
        chk("midload_rst_words", 64'({a_words, a_wdata}), 64'd0);

        sel = 1'b1;
        run_load(1'b1, 'h100, 1'b0, 1'b1, 1'b0);
        wait_done(4);
        chk("final_addr_b", 64'(b_addr), 64'h110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
